// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter that drives the 2-to-4 decoder.
// Holds the FSM encoding and the requester/address dimensions.
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter feeding the decoder.
// The slave side is the arbiter; the master side is whatever drives req/done.
interface rr_decoder_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int HOLD_W = 4
);

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic               addr0;
    logic               addr1;
    logic               enable;
    logic               timeout;
    logic [HOLD_W-1:0]  hold_count;

    modport master (
        output req, done,
        input  addr0, addr1, enable, timeout, hold_count
    );

    modport slave (
        input  req, done,
        output addr0, addr1, enable, timeout, hold_count
    );

endinterface

// File: rtl/rr_pick.sv
// Circular priority search: the first requester found starting at ptr wins.
// Purely combinational; shared by the IDLE and GAP arbitration.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ADDR_W-1:0]  ptr,
    output logic [ADDR_W-1:0]  pick,
    output logic               any_req
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ADDR_W-1:0]    off;

    // Rotate so ptr lands at bit 0, find the lowest set bit, then rotate the index back.
    always_comb begin
        dbl     = {req, req};
        rot     = dbl[ptr +: NUM_REQ];
        any_req = |req;
        if (rot[0]) begin
            off = 2'd0;
        end else if (rot[1]) begin
            off = 2'd1;
        end else if (rot[2]) begin
            off = 2'd2;
        end else if (rot[3]) begin
            off = 2'd3;
        end else begin
            off = 2'd0;
        end
        pick = ptr + off;
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter driving the decoder's addr/enable; decoder outputs act as grants.
// Break-before-make is enforced by a one-cycle GAP state between grants.
module rr_decoder_arbiter
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int HOLD_W   = 4
)(
    input  logic                 clk,
    input  logic                 reset_n,
    rr_decoder_arbiter_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [HOLD_W-1:0] HC_ONE    = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HC_ZERO   = HOLD_W'(0);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hc_q, hc_d;
    logic                enable_q, enable_d;
    logic                timeout_q, timeout_d;

    logic [ADDR_W-1:0]   pick;
    logic                any_req;
    logic                release_s;

    rr_pick u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .pick    (pick),
        .any_req (any_req)
    );

    // Next-state logic; release priority is done, then owner dropping req, then hold limit.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ptr_d     = ptr_q;
        hc_d      = hc_q;
        enable_d  = enable_q;
        timeout_d = 1'b0;
        release_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                hc_d = HC_ZERO;
                if (any_req) begin
                    state_d  = ST_GRANT;
                    addr_d   = pick;
                    enable_d = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    enable_d = 1'b0;
                end
            end
            ST_GRANT: begin
                release_s = bus.done || !bus.req[addr_q] || (hc_q == HOLD_LAST);
                if (release_s) begin
                    state_d   = ST_GAP;
                    enable_d  = 1'b0;
                    ptr_d     = addr_q + 2'd1;
                    hc_d      = HC_ZERO;
                    timeout_d = !bus.done && bus.req[addr_q];
                end else begin
                    // Release fires at HOLD_LAST, so the count never passes it.
                    enable_d = 1'b1;
                    hc_d     = hc_q + HC_ONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                enable_d = 1'b0;
                hc_d     = HC_ZERO;
            end
        endcase
    end

    // State and registered outputs; async reset drops enable without a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= 2'd0;
            ptr_q     <= 2'd0;
            hc_q      <= HC_ZERO;
            enable_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ptr_q     <= ptr_d;
            hc_q      <= hc_d;
            enable_q  <= enable_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.addr0      = addr_q[0];
    assign bus.addr1      = addr_q[1];
    assign bus.enable     = enable_q;
    assign bus.timeout    = timeout_q;
    assign bus.hold_count = hc_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Scoreboard bench for rr_decoder_arbiter: stimulus queues hand-computed
// post-edge outputs, a monitor pops and compares them after each rising edge.
module tb_rr_decoder_arbiter;

    typedef struct {
        logic       en;
        logic [1:0] addr;
        logic       to;
        logic [3:0] hc;
        string      nm;
    } exp_t;

    logic clk;
    logic reset_n;
    exp_t sb[$];
    int   errors;
    int   checks;

    rr_decoder_arbiter_if #(.HOLD_W(4)) bus ();

    rr_decoder_arbiter #(.HOLD_MAX(8), .HOLD_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic d, input logic en,
                       input logic [1:0] a, input logic to, input logic [3:0] hc,
                       input string nm);
        exp_t e;
        @(negedge clk);
        bus.req  = r;
        bus.done = d;
        e.en = en; e.addr = a; e.to = to; e.hc = hc; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: compare queued expectation two time units after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.nm, ".enable"},  {3'b000, bus.enable},           {3'b000, e.en});
                chk({e.nm, ".addr"},    {2'b00, bus.addr1, bus.addr0},  {2'b00, e.addr});
                chk({e.nm, ".timeout"}, {3'b000, bus.timeout},          {3'b000, e.to});
                chk({e.nm, ".hold"},    bus.hold_count,                 e.hc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors   = 0;
        checks   = 0;
        reset_n  = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst.enable",  {3'b000, bus.enable},          4'h0);
            chk("rst.addr",    {2'b00, bus.addr1, bus.addr0}, 4'h0);
            chk("rst.timeout", {3'b000, bus.timeout},         4'h0);
            chk("rst.hold",    bus.hold_count,                4'h0);
        end
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, "idle");

        // Single requester 2 released by done on the fourth edge
        cyc(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0, 4'd0, "single0");
        cyc(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0, 4'd1, "single1");
        cyc(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0, 4'd2, "single2");
        cyc(4'b0100, 1'b1, 1'b0, 2'd2, 1'b0, 4'd0, "single_rel");
        cyc(4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 4'd0, "single_idle");

        // All request, done on second grant cycle; ptr=3 so order is 3,0,1,2,3,0
        for (int k = 0; k < 6; k++) begin
            logic [1:0] g;
            g = 2'((3 + k) % 4);
            cyc(4'b1111, 1'b1, 1'b1, g, 1'b0, 4'd0, "rr_arb");
            cyc(4'b1111, 1'b0, 1'b1, g, 1'b0, 4'd1, "rr_hold");
            cyc(4'b1111, 1'b1, 1'b0, g, 1'b0, 4'd0, "rr_gap");
        end
        cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, "rr_idle");

        // Requester 1 never says done: 8 grant cycles, timeout pulse, regrant
        for (int rep = 0; rep < 2; rep++) begin
            cyc(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0, 4'd0, "to_arb");
            for (int h = 1; h < 8; h++)
                cyc(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0, 4'(h), "to_hold");
            cyc(4'b0010, 1'b0, 1'b0, 2'd1, 1'b1, 4'd0, "to_pulse");
        end
        cyc(4'b0000, 1'b0, 1'b0, 2'd1, 1'b0, 4'd0, "to_idle");

        // ptr=2, req 0 and 1: owner 0 not preempted, done at limit beats timeout
        cyc(4'b0011, 1'b0, 1'b1, 2'd0, 1'b0, 4'd0, "lim_arb");
        for (int h = 1; h < 8; h++)
            cyc(4'b0011, 1'b0, 1'b1, 2'd0, 1'b0, 4'(h), "lim_hold");
        cyc(4'b0011, 1'b1, 1'b0, 2'd0, 1'b0, 4'd0, "lim_done");
        cyc(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, "lim_idle");

        // ptr=1: grant 3, owner drops req -> release without timeout
        cyc(4'b1000, 1'b0, 1'b1, 2'd3, 1'b0, 4'd0, "drop_arb");
        cyc(4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0, "drop_rel");
        cyc(4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0, "drop_idle");

        // ptr=0: grant 2, then async reset between edges
        cyc(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0, 4'd0, "ar_arb");
        cyc(4'b0100, 1'b0, 1'b1, 2'd2, 1'b0, 4'd1, "ar_hold");
        @(posedge clk);
        #4;
        reset_n = 1'b0;
        #1;
        chk("async.enable", {3'b000, bus.enable},          4'h0);
        chk("async.addr",   {2'b00, bus.addr1, bus.addr0}, 4'h0);
        chk("async.hold",   bus.hold_count,                4'h0);
        @(negedge clk);
        bus.req = 4'b0000;
        reset_n = 1'b1;
        cyc(4'b1000, 1'b0, 1'b1, 2'd3, 1'b0, 4'd0, "post_rst_arb");
        cyc(4'b1000, 1'b1, 1'b0, 2'd3, 1'b0, 4'd0, "post_rst_rel");
        cyc(4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0, "post_rst_idle");

        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 2-to-4 decoder.
- Accepts four request lines and drives the decoder's addr0, addr1 and enable inputs.
- The decoder's one-hot outputs out0..out3 then act as the grant lines.
- Guarantees break-before-make: enable is low for at least one cycle between consecutive grants. Also bounds how long any requester may hold a grant.

Parameters:
- HOLD_MAX, 8: maximum grant length in cycles before forced release (legal range 2..15).
- HOLD_W, 4: width of the hold counter; must satisfy 2^HOLD_W > HOLD_MAX.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; req[i] asks for decoder output i.
- done  input  1  current owner releases its grant; sampled only in GRANT.
- addr0  output  1  decoder address LSB.
- addr1  output  1  decoder address MSB. Granted index = 2*addr1 + addr0.
- enable  output  1  decoder enable; high only in GRANT.
- timeout  output  1  one-cycle pulse when a grant is force-released at HOLD_MAX.
- hold_count  output  HOLD_W  cycles elapsed in the current grant; 0 outside GRANT.

Behaviour:
- Reset (async assert, sync deassert at the next edge):
  - state=IDLE, enable=0, addr1:addr0=00, ptr=0, hold_count=0, timeout=0.
  - Asserting reset_n mid-grant drops enable immediately, without waiting for a clock edge.
- All outputs are registered. No combinational path exists from req or done to any output.
- ptr (2 bits) is the first index searched.
  - Pick = lowest i in the circular order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1.
- IDLE:
  - enable=0.
  - If any req is high at an edge, go to GRANT. addr takes the picked index, enable=1, hold_count=0, all visible after that same edge. Latency is one edge.
  - Otherwise stay in IDLE.
- GRANT:
  - enable=1; addr is held stable.
  - hold_count increments each cycle, saturating at HOLD_MAX-1.
  - Release conditions, evaluated at each edge, in priority order:
    - (a) done=1.
    - (b) req[owner]=0.
    - (c) hold_count==HOLD_MAX-1. Only this case sets timeout=1, for exactly the cycle following the release edge.
  - On release: go to GAP, enable=0, ptr=owner+1 (mod 4, so 3 wraps to 0), hold_count=0.
  - If done coincides with the timeout count, done wins and timeout stays 0.
  - Requests from non-owners never preempt the owner.
- GAP:
  - enable=0 for exactly one cycle.
  - addr keeps the last owner, so the decoder inputs never glitch.
  - At the next edge, arbitrate exactly as IDLE does, using the updated ptr: go to GRANT if any req is high, else go to IDLE.
  - The previous owner may win again only if it is the sole requester.
- done is ignored in IDLE and in GAP.
- req changes while in GAP take effect at the GAP exit edge.
- Illegal state encodings recover to IDLE with enable=0.

Decomposition:
- Shared package rr_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2;
  - NUM_REQ=4;
  - ADDR_W=2.
- One combinational sub-module, rr_pick:
  - inputs req[3:0] and ptr[1:0];
  - outputs pick[1:0] and any_req.
  - It is reused by the IDLE and GAP arbitration.
- FSM, ptr register and hold counter stay in the top module.

Test Plan:
- Reset idle: reset_n=0 for 3 cycles, then req=0000 for 10 cycles -> enable=0, addr1:addr0=00, timeout=0, hold_count=0 throughout.
- Single requester with done: req=0100 before edge k, done=1 sampled at edge k+3 -> enable=1, addr1:addr0=10 from edge k to k+3. hold_count reads 0,1,2 over that span. enable=0 after edge k+3, ptr=3.
- Round-robin fairness: req=1111 held, owner asserts done on its second grant cycle -> grant order 0,1,2,3,0. Each grant lasts 2 cycles, followed by exactly 1 cycle with enable=0.
- Timeout: req=0010 held, done never asserted -> enable=1 with addr=01 for 8 cycles. timeout=1 for one cycle in GAP, then regrant to 1, and this repeats.
- Priority at the limit: owner asserts done on the edge where hold_count=7 -> release occurs and timeout stays 0.
- Async reset mid-grant: pull reset_n low between edges during GRANT -> enable=0 before the next edge. After release with req=1000 -> grant to 3 one edge later (search starts at ptr=0).
